// File: rtl/bcd_conv_scheduler.sv
// Two-channel (X/Y) 8-bit binary-to-BCD converter with a round-robin request scheduler.
// Define BCD_SIGNED_EN to treat inputs as two's complement and convert the magnitude.
module bcd_conv_scheduler #(
    parameter logic START_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_x,
    input  logic [7:0] data_x,
    input  logic       req_y,
    input  logic [7:0] data_y,
    output logic       ack_x,
    output logic       ack_y,
    output logic       busy,
    output logic       valid,
    output logic       ch,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [1:0] hundreds,
    output logic       sign
);

    // state | meaning
    // IDLE  | waiting for a request; arbitrates and latches data on grant
    // CONV  | double-dabble, one bit per clock, cnt_q counts 7 down to 0
    typedef enum logic {IDLE, CONV} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  bin_q, bin_d;
    logic [9:0]  bcd_q, bcd_d;
    logic        last_q, last_d;
    logic        cur_ch_q, cur_ch_d;
    logic        cur_sign_q, cur_sign_d;
    logic        ack_x_q, ack_x_d, ack_y_q, ack_y_d, valid_q, valid_d;
    logic        ch_q, ch_d, sign_q, sign_d;
    logic [3:0]  ones_q, ones_d, tens_q, tens_d;
    logic [1:0]  hund_q, hund_d;

    logic [7:0]  mag_x, mag_y;
    logic        sgn_x, sgn_y;
    logic        gnt_y;
    logic [3:0]  adj_o, adj_t;
    logic [9:0]  step_bcd;

`ifdef BCD_SIGNED_EN
    // 8'h80 negates to itself, which reads correctly as unsigned 128
    assign mag_x = data_x[7] ? (~data_x + 8'd1) : data_x;
    assign mag_y = data_y[7] ? (~data_y + 8'd1) : data_y;
    assign sgn_x = data_x[7];
    assign sgn_y = data_y[7];
`else
    assign mag_x = data_x;
    assign mag_y = data_y;
    assign sgn_x = 1'b0;
    assign sgn_y = 1'b0;
`endif

    // Hundreds never exceeds 2 for 8-bit input, so it needs no +3 adjust
    always_comb begin
        adj_o    = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
        adj_t    = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
        step_bcd = {bcd_q[8], adj_t, adj_o, bin_q[7]};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        last_d     = last_q;
        cur_ch_d   = cur_ch_q;
        cur_sign_d = cur_sign_q;
        ack_x_d    = 1'b0;
        ack_y_d    = 1'b0;
        valid_d    = 1'b0;
        ch_d       = ch_q;
        sign_d     = sign_q;
        ones_d     = ones_q;
        tens_d     = tens_q;
        hund_d     = hund_q;
        gnt_y      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_x || req_y) begin
                    gnt_y      = req_y && (!req_x || !last_q);
                    state_d    = CONV;
                    cnt_d      = 3'd7;
                    bcd_d      = '0;
                    bin_d      = gnt_y ? mag_y : mag_x;
                    cur_sign_d = gnt_y ? sgn_y : sgn_x;
                    cur_ch_d   = gnt_y;
                    last_d     = gnt_y;
                    ack_x_d    = !gnt_y;
                    ack_y_d    = gnt_y;
                end
            end
            CONV: begin
                bcd_d = step_bcd;
                bin_d = {bin_q[6:0], 1'b0};
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd0) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    ones_d  = step_bcd[3:0];
                    tens_d  = step_bcd[7:4];
                    hund_d  = step_bcd[9:8];
                    ch_d    = cur_ch_q;
                    sign_d  = cur_sign_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            last_q     <= ~START_PRIO;
            cur_ch_q   <= 1'b0;
            cur_sign_q <= 1'b0;
            ack_x_q    <= 1'b0;
            ack_y_q    <= 1'b0;
            valid_q    <= 1'b0;
            ch_q       <= 1'b0;
            sign_q     <= 1'b0;
            ones_q     <= '0;
            tens_q     <= '0;
            hund_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            last_q     <= last_d;
            cur_ch_q   <= cur_ch_d;
            cur_sign_q <= cur_sign_d;
            ack_x_q    <= ack_x_d;
            ack_y_q    <= ack_y_d;
            valid_q    <= valid_d;
            ch_q       <= ch_d;
            sign_q     <= sign_d;
            ones_q     <= ones_d;
            tens_q     <= tens_d;
            hund_q     <= hund_d;
        end
    end

    assign ack_x    = ack_x_q;
    assign ack_y    = ack_y_q;
    assign busy     = (state_q == CONV);
    assign valid    = valid_q;
    assign ch       = ch_q;
    assign sign     = sign_q;
    assign ones     = ones_q;
    assign tens     = tens_q;
    assign hundreds = hund_q;

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Scoreboard bench for bcd_conv_scheduler: requesters push expected results on ack,
// a monitor pops and compares on every valid strobe.
module tb_bcd_conv_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_x = 1'b0, req_y = 1'b0;
    logic [7:0] data_x = '0, data_y = '0;
    logic       ack_x, ack_y, busy, valid, ch, sign;
    logic [3:0] ones, tens;
    logic [1:0] hundreds;

    typedef struct packed {
        logic       c;
        logic       s;
        logic [1:0] h;
        logic [3:0] t;
        logic [3:0] o;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   nvalid = 0;
    int   ack_cyc [2];
    int   vcyc [2];
    exp_t exp_q [$];
    bit   grant_q [$];
    exp_t last_exp = '0;

    bcd_conv_scheduler #(.START_PRIO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_x(req_x), .data_x(data_x), .req_y(req_y), .data_y(data_y),
        .ack_x(ack_x), .ack_y(ack_y), .busy(busy), .valid(valid), .ch(ch),
        .ones(ones), .tens(tens), .hundreds(hundreds), .sign(sign)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(bit c, bit s, int h, int t, int o);
        exp_t e;
        e.c = c; e.s = s; e.h = 2'(h); e.t = 4'(t); e.o = 4'(o);
        return e;
    endfunction

    task automatic check(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
        end
    endtask

    function automatic int outs();
        return int'({ch, sign, hundreds, tens, ones});
    endfunction

    // Monitor: compares every result strobe against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && (ack_x || ack_y))
                check("ack_exclusive", int'(ack_x && ack_y), 0);
            if (rst_n && valid) begin
                nvalid++;
                vcyc[ch] = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    last_exp = exp_q.pop_front();
                    check("result", outs(), int'(last_exp));
                    check("busy_low_on_valid", int'(busy), 0);
                end
            end
        end
    end

    // Called at a negedge: raise request, wait for ack, push the expected result.
    task automatic do_req(input bit c, input logic [7:0] d, input exp_t e);
        bit got = 1'b0;
        if (c) begin data_y = d; req_y = 1'b1; end
        else   begin data_x = d; req_x = 1'b1; end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if ((c && ack_y) || (!c && ack_x)) got = 1'b1;
        end
        if (!got) check(c ? "ack_y_timeout" : "ack_x_timeout", 0, 1);
        ack_cyc[c] = cyc;
        grant_q.push_back(c);
        exp_q.push_back(e);
        if (c) req_y = 1'b0; else req_x = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("drain_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int rcyc, nv;
        exp_t e255, e201, ef6, e80;
        bit   got;
`ifdef BCD_SIGNED_EN
        e255 = mk(0, 1, 0, 0, 1);
        e201 = mk(1, 1, 0, 5, 5);
        ef6  = mk(0, 1, 0, 1, 0);
        e80  = mk(0, 1, 1, 2, 8);
`else
        e255 = mk(0, 0, 2, 5, 5);
        e201 = mk(1, 0, 2, 0, 1);
        ef6  = mk(0, 0, 2, 4, 6);
        e80  = mk(0, 0, 1, 2, 8);
`endif
        repeat (2) @(negedge clk);
        check("reset_outputs", int'({ack_x, ack_y, busy, valid, ch, sign, hundreds, tens, ones}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single X request, full-scale value, latency and ack shape
        rcyc = cyc;
        do_req(0, 8'd255, e255);
        check("ack_latency", ack_cyc[0] - rcyc, 1);
        check("busy_with_ack", int'(busy), 1);
        @(negedge clk);
        check("ack_one_pulse", int'(ack_x), 0);
        drain();
        check("valid_latency_from_req", vcyc[0] - rcyc, 9);
        repeat (4) @(negedge clk);
        check("result_hold", outs(), int'(last_exp));

        // Simultaneous requests after reset: X first, then alternation
        do_reset();
        grant_q.delete();
        fork
            do_req(0, 8'd100, mk(0, 0, 1, 0, 0));
            do_req(1, 8'd7,   mk(1, 0, 0, 0, 7));
        join
        drain();
        fork
            do_req(0, 8'd100, mk(0, 0, 1, 0, 0));
            do_req(1, 8'd7,   mk(1, 0, 0, 0, 7));
        join
        drain();
        check("grant_count", grant_q.size(), 4);
        if (grant_q.size() == 4)
            check("grant_order", int'({grant_q[0], grant_q[1], grant_q[2], grant_q[3]}), 4'b0101);

        // Y raised during the 3rd X iteration waits for IDLE
        fork
            do_req(0, 8'd58, mk(0, 0, 0, 5, 8));
            begin
                repeat (3) @(negedge clk);
                do_req(1, 8'd201, e201);
            end
        join
        drain();
        check("y_ack_after_x_valid", ack_cyc[1] - vcyc[0], 1);
        check("y_valid_latency", vcyc[1] - ack_cyc[1], 8);

        // Reset during the 4th iteration aborts; held request is re-granted
        data_x = 8'd42;
        req_x  = 1'b1;
        got    = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ack_x) got = 1'b1;
        end
        check("abort_first_ack", int'(got), 1);
        nv = nvalid;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_outputs_zero", int'({ack_x, ack_y, busy, valid, ch, sign, hundreds, tens, ones}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ack_x) got = 1'b1;
        end
        check("abort_reack", int'(got), 1);
        check("abort_no_valid", nvalid - nv, 0);
        exp_q.push_back(mk(0, 0, 0, 4, 2));
        req_x = 1'b0;
        drain();

        // Signed-mode corner values
        do_req(0, 8'h80, e80);
        drain();
        do_req(1, 8'hF6, mk(1, ef6.s, int'(ef6.h), int'(ef6.t), int'(ef6.o)));
        drain();
        do_req(0, 8'd0, mk(0, 0, 0, 0, 0));
        drain();
        check("leftover_expected", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bcd_conv_scheduler.md
BCD_CONV_SCHEDULER -- requirements
Module: bcd_conv_scheduler

Interface
REQ-001 SHALL have parameter: START_PRIO, 0, channel (0=X, 1=Y) granted first on simultaneous requests after reset.
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_x  input  1  X-channel conversion request, level, held until ack_x.
REQ-005 SHALL have port: data_x  input  8  X-channel mouse value.
REQ-006 SHALL have port: req_y  input  1  Y-channel conversion request, level, held until ack_y.
REQ-007 SHALL have port: data_y  input  8  Y-channel mouse value.
REQ-008 SHALL have ports: ack_x, ack_y  output  1 each  one-cycle grant/data-taken pulse.
REQ-009 SHALL have port: busy  output  1  conversion in progress.
REQ-010 SHALL have port: valid  output  1  one-cycle result strobe.
REQ-011 SHALL have port: ch  output  1  channel owning current result (0=X, 1=Y).
REQ-012 SHALL have ports: ones  output  4; tens  output  4; hundreds  output  2  registered BCD result.
REQ-013 SHALL have port: sign  output  1  result negative (macro-dependent, REQ-027/028).

Function
REQ-014 SHALL implement FSM states IDLE and CONV with a 3-bit iteration counter.
REQ-015 In IDLE, at an edge with req_x or req_y high, SHALL grant one channel, latch its data, pulse its ack in the following cycle, enter CONV; busy high from that cycle.
REQ-016 Arbitration SHALL be round-robin: single request wins; on both, the channel not granted last wins.
REQ-017 CONV SHALL perform exactly 8 iterations, one per clock, MSB first: add 3 to each BCD digit >= 5, then shift left one bit.
REQ-018 At the 8th CONV edge SHALL load ones/tens/hundreds/ch/sign, pulse valid one cycle, deassert busy in that cycle, return to IDLE.
REQ-019 Latency: result and valid SHALL be visible in the cycle after the 9th edge following the sampled request edge; back-to-back throughput one conversion per 9 cycles.
REQ-020 Requests arriving during CONV SHALL NOT be acknowledged until IDLE; a request dropped before its ack SHALL be ignored.
REQ-021 Result outputs SHALL hold the last value until the next valid.
REQ-022 ack_x and ack_y SHALL never be high in the same cycle; each ack SHALL coincide with data latch of its channel only.
REQ-023 Input range 0..255 SHALL yield hundreds 0..2 with no overflow.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, counter 0, ack_x/ack_y/busy/valid/ch/sign 0, ones/tens/hundreds 0.
REQ-025 Round-robin pointer SHALL reset so channel START_PRIO wins the first simultaneous request.
REQ-026 Reset mid-CONV SHALL abort without valid; held requests SHALL be re-granted after release.

Configuration
REQ-027 With BCD_SIGNED_EN defined: data SHALL be two's complement; conversion on magnitude; sign = bit 7 of latched data; 8'h80 gives magnitude 128.
REQ-028 Without BCD_SIGNED_EN: data unsigned, sign SHALL be constant 0.

Verification
REQ-029 Unsigned, req_x data_x=8'd255 -> ack_x one pulse, valid 9 edges later, ch=0, hundreds=2 tens=5 ones=5.
REQ-030 After reset, START_PRIO=0, req_x (8'd100) and req_y (8'd7) held together -> X first (1,0,0), then Y (0,0,7); re-raised both -> X granted next, alternation continues.
REQ-031 req_y raised during 3rd X iteration -> no ack_y until X valid cycle's following IDLE edge; Y result follows 9 cycles later.
REQ-032 rst_n pulsed low at 4th iteration -> all outputs 0 immediately, no valid; held req re-acked after release and converts correctly.
REQ-033 BCD_SIGNED_EN: 8'h80 -> sign=1, 1/2/8; 8'hF6 -> sign=1, 0/1/0; 8'd0 -> sign=0, 0/0/0. Without macro: 8'h80 -> sign=0, 1/2/8.
